// File: rtl/ct_lsu_snoop_ctcq_fifo_if.sv
// ct_lsu_snoop_ctcq_fifo_if: handshake/bus bundle for the CTC maintenance request queue.
//   create_*  : 1- or 2-beat request beats from the snoop side (vld/rdy)
//   req_*     : head request to the invalidation engine (vld/ack) with decoded type and addresses
//   inv_cmplt : completion pulse from the engine
//   resp_*    : one response beat per received create beat (vld/rdy), resp_last retires the entry
//   q_empty/q_full : queue occupancy status
// master drives the snoop/engine side (testbench), slave is the queue.
interface ct_lsu_snoop_ctcq_fifo_if #(
    parameter int PA_WIDTH = 40,
    parameter int VA_WIDTH = 39
);
    logic                create_vld;
    logic                create_rdy;
    logic                create_2nd_trans;
    logic [5:0]          create_type;
    logic [15:0]         create_asid_va;
    logic [PA_WIDTH-5:0] create_va_pa;
    logic                req_vld;
    logic                req_ack;
    logic                req_icache_all_inv;
    logic                req_icache_line_inv;
    logic                req_tlb_all_inv;
    logic                req_tlb_va_all_inv;
    logic                req_tlb_asid_inv;
    logic                req_tlb_va_asid_inv;
    logic [15:0]         req_asid;
    logic [5:0]          req_icache_index;
    logic [PA_WIDTH-13:0] req_icache_ptag;
    logic [VA_WIDTH-13:0] req_tlb_va;
    logic                inv_cmplt;
    logic                resp_vld;
    logic                resp_rdy;
    logic                resp_last;
    logic                q_empty;
    logic                q_full;

    modport master (
        output create_vld, create_2nd_trans, create_type, create_asid_va, create_va_pa,
        output req_ack, inv_cmplt, resp_rdy,
        input  create_rdy, req_vld, req_icache_all_inv, req_icache_line_inv,
        input  req_tlb_all_inv, req_tlb_va_all_inv, req_tlb_asid_inv, req_tlb_va_asid_inv,
        input  req_asid, req_icache_index, req_icache_ptag, req_tlb_va,
        input  resp_vld, resp_last, q_empty, q_full
    );

    modport slave (
        input  create_vld, create_2nd_trans, create_type, create_asid_va, create_va_pa,
        input  req_ack, inv_cmplt, resp_rdy,
        output create_rdy, req_vld, req_icache_all_inv, req_icache_line_inv,
        output req_tlb_all_inv, req_tlb_va_all_inv, req_tlb_asid_inv, req_tlb_va_asid_inv,
        output req_asid, req_icache_index, req_icache_ptag, req_tlb_va,
        output resp_vld, resp_last, q_empty, q_full
    );
endinterface

// File: rtl/ct_lsu_snoop_ctcq_fifo.sv
// ct_lsu_snoop_ctcq_fifo: in-order multi-entry CTC (icache/TLB maintenance) request queue.
//   lsu_snoop_clk : clock
//   cpurst_b      : asynchronous active-low reset
//   bus (slave)   : create beats in, head request/ack to the invalidation engine,
//                   completion pulse, per-beat responses out, empty/full status
// The head entry is issued through IDLE -> REQ -> WAIT -> RESP; one response is
// returned per received create beat and the last one retires the entry.
module ct_lsu_snoop_ctcq_fifo #(
    parameter int DEPTH    = 4,
    parameter int PTR_W    = 2,
    parameter int PA_WIDTH = 40,
    parameter int VA_WIDTH = 39
) (
    input logic                     lsu_snoop_clk,
    input logic                     cpurst_b,
    ct_lsu_snoop_ctcq_fifo_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t state, state_nxt;

    // Only the bits that feed the decode and address outputs are stored:
    // type as {t[4], t[2:0]} and va_pa from bit 2 upwards.
    logic [DEPTH-1:0]    ent_vld, ent_two, ent_addr;
    logic [3:0]          ent_type [DEPTH];
    logic [15:0]         ent_asid [DEPTH];
    logic [PA_WIDTH-7:0] ent_va   [DEPTH];

    logic [PTR_W-1:0] head, tail, pend_ptr;
    logic [PTR_W:0]   cnt;
    logic             pending_2nd;
    logic [1:0]       resp_cnt;

    logic create_fire, first_beat, second_beat;
    logic head_ready, load_resp, resp_fire, retire;
    logic [3:0]          head_type;
    logic [PA_WIDTH-7:0] head_va;
    logic                unused_bits;

    assign unused_bits = ^{bus.create_type[5], bus.create_type[3], bus.create_va_pa[1:0]};

    assign bus.q_full     = cnt == (PTR_W+1)'(DEPTH);
    assign bus.q_empty    = cnt == '0;
    assign bus.create_rdy = pending_2nd | !bus.q_full;

    assign create_fire = bus.create_vld & bus.create_rdy;
    assign first_beat  = create_fire & !pending_2nd;
    assign second_beat = create_fire & pending_2nd;

    assign head_ready = ent_vld[head] & (!ent_two[head] | ent_addr[head]);
    // Completion counts in WAIT, or in REQ when it coincides with the ack.
    assign load_resp  = bus.inv_cmplt & ((state == WAIT) | (state == REQ & bus.req_ack));
    assign resp_fire  = (state == RESP) & bus.resp_rdy;
    assign retire     = resp_fire & (resp_cnt == 2'd1);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = head_ready ? REQ : IDLE;
            REQ:     state_nxt = bus.req_ack ? (bus.inv_cmplt ? RESP : WAIT) : REQ;
            WAIT:    state_nxt = bus.inv_cmplt ? RESP : WAIT;
            default: state_nxt = retire ? IDLE : RESP;
        endcase
    end

    always_ff @(posedge lsu_snoop_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state    <= IDLE;
            resp_cnt <= '0;
        end else begin
            state    <= state_nxt;
            resp_cnt <= load_resp ? (ent_two[head] ? 2'd2 : 2'd1) :
                        resp_fire ? resp_cnt - 2'd1 : resp_cnt;
        end
    end

    always_ff @(posedge lsu_snoop_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            ent_vld     <= '0;
            ent_two     <= '0;
            ent_addr    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_type[i] <= '0;
                ent_asid[i] <= '0;
                ent_va[i]   <= '0;
            end
            head        <= '0;
            tail        <= '0;
            pend_ptr    <= '0;
            cnt         <= '0;
            pending_2nd <= 1'b0;
        end else begin
            if (first_beat) begin
                ent_vld[tail]  <= 1'b1;
                ent_two[tail]  <= bus.create_2nd_trans;
                ent_addr[tail] <= 1'b0;
                ent_type[tail] <= {bus.create_type[4], bus.create_type[2:0]};
                ent_asid[tail] <= bus.create_asid_va;
                tail           <= tail + 1'b1;
                pending_2nd    <= bus.create_2nd_trans;
                pend_ptr       <= tail;
            end
            if (second_beat) begin
                ent_va[pend_ptr]   <= bus.create_va_pa[PA_WIDTH-5:2];
                ent_addr[pend_ptr] <= 1'b1;
                pending_2nd        <= 1'b0;
            end
            if (retire) begin
                ent_vld[head] <= 1'b0;
                head          <= head + 1'b1;
            end
            cnt <= cnt + (PTR_W+1)'(first_beat) - (PTR_W+1)'(retire);
        end
    end

    assign head_type = ent_type[head];
    assign head_va   = ent_va[head];

    assign bus.req_vld             = state == REQ;
    assign bus.req_icache_all_inv  = bus.req_vld & (head_type == 4'b1000);
    assign bus.req_icache_line_inv = bus.req_vld & (head_type == 4'b1001);
    assign bus.req_tlb_all_inv     = bus.req_vld & (head_type == 4'b0000);
    assign bus.req_tlb_va_all_inv  = bus.req_vld & (head_type == 4'b0001);
    assign bus.req_tlb_asid_inv    = bus.req_vld & (head_type == 4'b0010);
    assign bus.req_tlb_va_asid_inv = bus.req_vld & (head_type == 4'b0011);
    assign bus.req_asid            = bus.req_vld ? ent_asid[head] : '0;
    assign bus.req_icache_index    = bus.req_vld ? head_va[5:0] : '0;
    assign bus.req_icache_ptag     = bus.req_vld ? head_va[PA_WIDTH-7:6] : '0;
    assign bus.req_tlb_va          = bus.req_vld ? head_va[VA_WIDTH-7:6] : '0;

    assign bus.resp_vld  = state == RESP;
    assign bus.resp_last = bus.resp_vld & (resp_cnt == 2'd1);
endmodule

// File: tb/tb_ct_lsu_snoop_ctcq_fifo.sv
// tb_ct_lsu_snoop_ctcq_fifo: scoreboard bench for the CTC request queue.
module tb_ct_lsu_snoop_ctcq_fifo;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ct_lsu_snoop_ctcq_fifo_if bus ();

    ct_lsu_snoop_ctcq_fifo dut (
        .lsu_snoop_clk(clk),
        .cpurst_b(rst_n),
        .bus(bus)
    );

    typedef struct {
        logic [5:0]  dec;
        logic [15:0] asid;
        bit          chk_addr;
        logic [5:0]  idx;
        logic [27:0] ptag;
        logic [26:0] tva;
    } req_t;

    req_t exp_req[$];
    bit   exp_last[$];
    req_t e;
    int   checks = 0;
    int   errors = 0;

    localparam logic [5:0] D_IC_ALL = 6'b100000, D_IC_LINE = 6'b010000, D_TLB_ALL = 6'b001000,
                           D_TLB_VA_ALL = 6'b000100, D_TLB_ASID = 6'b000010, D_TLB_VA_ASID = 6'b000001;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    task automatic expect_req(input logic [5:0] dec, input logic [15:0] asid, input bit two,
                              input logic [5:0] idx, input logic [27:0] ptag, input logic [26:0] tva);
        req_t r;
        r.dec = dec; r.asid = asid; r.chk_addr = two; r.idx = idx; r.ptag = ptag; r.tva = tva;
        exp_req.push_back(r);
        if (two) exp_last.push_back(1'b0);
        exp_last.push_back(1'b1);
    endtask

    // Monitor: pops the scoreboard whenever the DUT hands over a request or a response beat.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.req_vld && bus.req_ack) begin
                if (exp_req.size() == 0) fail("unexpected req");
                else begin
                    e = exp_req.pop_front();
                    chk("req decode", {bus.req_icache_all_inv, bus.req_icache_line_inv, bus.req_tlb_all_inv,
                                       bus.req_tlb_va_all_inv, bus.req_tlb_asid_inv, bus.req_tlb_va_asid_inv}, e.dec);
                    chk("req asid", bus.req_asid, e.asid);
                    if (e.chk_addr) begin
                        chk("req icache_index", bus.req_icache_index, e.idx);
                        chk("req icache_ptag", bus.req_icache_ptag, e.ptag);
                        chk("req tlb_va", bus.req_tlb_va, e.tva);
                    end
                end
            end
            if (!bus.req_vld)
                chk("idle payload zero", |{bus.req_icache_all_inv, bus.req_icache_line_inv, bus.req_tlb_all_inv,
                                           bus.req_tlb_va_all_inv, bus.req_tlb_asid_inv, bus.req_tlb_va_asid_inv,
                                           bus.req_asid, bus.req_icache_index, bus.req_icache_ptag, bus.req_tlb_va}, 0);
            if (bus.resp_vld && bus.resp_rdy) begin
                if (exp_last.size() == 0) fail("unexpected resp");
                else chk("resp_last", bus.resp_last, exp_last.pop_front());
            end
        end
    end

    // sel: 0 req_vld, 1 q_empty, 2 resp_vld, 3 !q_full
    task automatic wait_cond(input int sel, input string name);
        bit hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            hit = sel == 0 ? bus.req_vld : sel == 1 ? bus.q_empty : sel == 2 ? bus.resp_vld : !bus.q_full;
        end
        if (!hit) fail({"timeout ", name});
    endtask

    task automatic create_beat(input bit two, input logic [5:0] t, input logic [15:0] a,
                               input logic [35:0] v, input bit exp_acc, input string name);
        @(posedge clk); #1;
        bus.create_vld = 1'b1;
        bus.create_2nd_trans = two;
        bus.create_type = t;
        bus.create_asid_va = a;
        bus.create_va_pa = v;
        @(negedge clk);
        chk(name, bus.create_rdy, exp_acc);
        @(posedge clk); #1;
        bus.create_vld = 1'b0;
        bus.create_2nd_trans = 1'b0;
    endtask

    task automatic serve(input bit same);
        wait_cond(0, "req_vld");
        @(posedge clk); #1;
        bus.req_ack = 1'b1;
        bus.inv_cmplt = same;
        @(posedge clk); #1;
        bus.req_ack = 1'b0;
        bus.inv_cmplt = 1'b0;
        if (!same) begin
            bus.inv_cmplt = 1'b1;
            @(posedge clk); #1;
            bus.inv_cmplt = 1'b0;
        end
    endtask

    initial begin
        bus.create_vld = 0; bus.create_2nd_trans = 0; bus.create_type = 0;
        bus.create_asid_va = 0; bus.create_va_pa = 0;
        bus.req_ack = 0; bus.inv_cmplt = 0; bus.resp_rdy = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset outputs", {bus.create_rdy, bus.q_empty, bus.q_full, bus.req_vld, bus.resp_vld, bus.resp_last}, 6'b110000);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // single-beat TLB all invalidate
        expect_req(D_TLB_ALL, 16'h0055, 0, 0, 0, 0);
        create_beat(0, 6'h00, 16'h0055, 36'h0, 1, "create 1beat");
        @(negedge clk);
        chk("not empty after create", bus.q_empty, 0);
        serve(0);
        wait_cond(1, "empty after 1beat");

        // two-beat icache line invalidate: no issue until beat 2
        create_beat(1, 6'h11, 16'h1234, 36'h0, 1, "create ici beat1");
        repeat (3) begin
            @(negedge clk);
            chk("no issue before beat2", bus.req_vld, 0);
        end
        expect_req(D_IC_LINE, 16'h1234, 1, 6'h2A, 28'hABCDEF0, 27'h2BCDEF0);
        create_beat(0, 6'h00, 16'h0, 36'hA_BCDE_F0A8, 1, "create ici beat2");
        serve(0);
        wait_cond(1, "empty after ici");

        // fill to full, refuse, retire one, wrap, in-order issue
        expect_req(D_IC_ALL, 16'h0001, 0, 0, 0, 0);
        expect_req(D_TLB_VA_ALL, 16'h0002, 0, 0, 0, 0);
        expect_req(D_TLB_ASID, 16'h0003, 0, 0, 0, 0);
        expect_req(D_TLB_VA_ASID, 16'h0004, 0, 0, 0, 0);
        create_beat(0, 6'h10, 16'h0001, 36'h0, 1, "fill 1");
        create_beat(0, 6'h01, 16'h0002, 36'h0, 1, "fill 2");
        create_beat(0, 6'h02, 16'h0003, 36'h0, 1, "fill 3");
        create_beat(0, 6'h03, 16'h0004, 36'h0, 1, "fill 4");
        @(negedge clk);
        chk("full status", {bus.q_full, bus.create_rdy}, 2'b10);
        create_beat(0, 6'h00, 16'h00EE, 36'h0, 0, "create at full refused");
        serve(1);
        wait_cond(3, "not full after retire");
        chk("create_rdy after retire", bus.create_rdy, 1);
        expect_req(D_TLB_ALL, 16'h0005, 0, 0, 0, 0);
        create_beat(0, 6'h08, 16'h0005, 36'h0, 1, "create after wrap");
        repeat (4) serve(0);
        wait_cond(1, "empty after fill");

        // full with a pending second beat: beat 2 still accepted
        expect_req(D_TLB_ALL, 16'h0031, 0, 0, 0, 0);
        expect_req(D_TLB_ALL, 16'h0032, 0, 0, 0, 0);
        expect_req(D_TLB_ALL, 16'h0033, 0, 0, 0, 0);
        expect_req(D_TLB_VA_ASID, 16'hABCD, 1, 6'h00, 28'h0000001, 27'h0000001);
        create_beat(0, 6'h00, 16'h0031, 36'h0, 1, "pend fill 1");
        create_beat(0, 6'h00, 16'h0032, 36'h0, 1, "pend fill 2");
        create_beat(0, 6'h00, 16'h0033, 36'h0, 1, "pend fill 3");
        create_beat(1, 6'h03, 16'hABCD, 36'h0, 1, "pend fill 4 beat1");
        @(negedge clk);
        chk("full with pending", {bus.q_full, bus.create_rdy}, 2'b11);
        create_beat(0, 6'h00, 16'h0, 36'h0_0000_0100, 1, "beat2 at full");
        repeat (4) serve(0);
        wait_cond(1, "empty after pending");

        // response backpressure
        bus.resp_rdy = 1'b0;
        expect_req(D_TLB_ASID, 16'h0077, 0, 0, 0, 0);
        expect_req(D_TLB_VA_ALL, 16'h0088, 0, 0, 0, 0);
        create_beat(0, 6'h02, 16'h0077, 36'h0, 1, "bp create 1");
        create_beat(0, 6'h01, 16'h0088, 36'h0, 1, "bp create 2");
        serve(0);
        wait_cond(2, "resp_vld");
        repeat (5) begin
            @(negedge clk);
            chk("held resp", {bus.resp_vld, bus.req_vld, bus.q_empty}, 3'b100);
        end
        @(posedge clk); #1;
        bus.resp_rdy = 1'b1;
        serve(0);
        wait_cond(1, "empty after backpressure");

        // spurious completions in IDLE and REQ
        @(posedge clk); #1;
        bus.inv_cmplt = 1'b1;
        @(posedge clk); #1;
        bus.inv_cmplt = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("spurious in idle", {bus.resp_vld, bus.req_vld, bus.q_empty}, 3'b001);
        end
        expect_req(D_TLB_ALL, 16'h0009, 0, 0, 0, 0);
        create_beat(0, 6'h00, 16'h0009, 36'h0, 1, "spur create");
        wait_cond(0, "req_vld spur");
        @(posedge clk); #1;
        bus.inv_cmplt = 1'b1;
        @(posedge clk); #1;
        bus.inv_cmplt = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("spurious in req", {bus.req_vld, bus.resp_vld}, 2'b10);
        end
        serve(0);
        wait_cond(1, "empty after spurious");

        // reset while waiting for completion
        expect_req(D_TLB_VA_ALL, 16'h0042, 0, 0, 0, 0);
        create_beat(0, 6'h01, 16'h0042, 36'h0, 1, "rst create");
        wait_cond(0, "req_vld rst");
        @(posedge clk); #1;
        bus.req_ack = 1'b1;
        @(posedge clk); #1;
        bus.req_ack = 1'b0;
        rst_n = 1'b0;
        exp_last.delete();
        @(negedge clk);
        chk("outputs in reset", {bus.create_rdy, bus.q_empty, bus.q_full, bus.req_vld, bus.resp_vld, bus.resp_last}, 6'b110000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.inv_cmplt = 1'b1;
        @(posedge clk); #1;
        bus.inv_cmplt = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("cmplt after reset ignored", {bus.resp_vld, bus.req_vld, bus.q_empty}, 3'b001);
        end

        chk("req scoreboard drained", exp_req.size(), 0);
        chk("resp scoreboard drained", exp_last.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
